// File: rtl/bsram_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// bsram_arb_pkg
// Shared types and default sizes for the BSRAM boot/fetch arbiter.
//   arb_state_t  : arbiter mode (BOOT while the loader fills memory, RUN after)
//   AW_DEF       : default memory address width
//   DW_DEF       : default memory data width
//   RD_LAT_DEF   : default BSRAM read latency in clk cycles (1 or 2)
// ---------------------------------------------------------------------------
package bsram_arb_pkg;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } arb_state_t;

    localparam int AW_DEF     = 11;
    localparam int DW_DEF     = 16;
    localparam int RD_LAT_DEF = 1;

endpackage

// File: rtl/bsram_arbiter_if.sv
// ---------------------------------------------------------------------------
// bsram_arbiter_if
// Bundles the loader write port, the CPU fetch port and the BSRAM port of
// the arbiter.
//   slave  modport : the arbiter's view (requests in, grants/memory out)
//   master modport : the requester/memory view (requests out, grants in)
// Signals:
//   ld_req/ld_addr/ld_wdata/ld_gnt : loader write port
//   ld_done                        : one-cycle pulse, end of boot image
//   cpu_req/cpu_addr/cpu_gnt       : CPU fetch request port
//   cpu_rvalid/cpu_rdata           : fetch response
//   cpu_hold                       : CPU stall while boot is incomplete
//   mem_ce/mem_wre/mem_ad/mem_din/mem_dout : single-port BSRAM
//   state                          : current arbiter mode, for observation
//
// Handshake: a transfer happens on the rising clk edge where req and gnt are
// both high; the requester keeps addr/wdata stable until that edge, and the
// grant may be computed combinationally from req in the same cycle.
// ---------------------------------------------------------------------------
interface bsram_arbiter_if
    import bsram_arb_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) ();

    logic          ld_req;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_wdata;
    logic          ld_gnt;
    logic          ld_done;

    logic          cpu_req;
    logic [AW-1:0] cpu_addr;
    logic          cpu_gnt;
    logic          cpu_rvalid;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_hold;

    logic          mem_ce;
    logic          mem_wre;
    logic [AW-1:0] mem_ad;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;

    arb_state_t    state;

    modport slave (
        input  ld_req, ld_addr, ld_wdata, ld_done,
        input  cpu_req, cpu_addr,
        input  mem_dout,
        output ld_gnt, cpu_gnt, cpu_rvalid, cpu_rdata, cpu_hold,
        output mem_ce, mem_wre, mem_ad, mem_din,
        output state
    );

    modport master (
        output ld_req, ld_addr, ld_wdata, ld_done,
        output cpu_req, cpu_addr,
        output mem_dout,
        input  ld_gnt, cpu_gnt, cpu_rvalid, cpu_rdata, cpu_hold,
        input  mem_ce, mem_wre, mem_ad, mem_din,
        input  state
    );

endinterface

// File: rtl/bsram_arbiter_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-requester grant logic (loader vs CPU). Grants are combinational from
// the requests and at most one grant is high per cycle.
// Build option BSRAM_ARB_RR_EN:
//   defined   : ties go to the requester not granted last; the last-granted
//               pointer updates on every grant (a grant is a handshake since
//               it is only ever raised together with its request). Reset
//               points at the loader, so the CPU wins the first tie.
//   undefined : fixed priority, loader wins ties; no pointer register and no
//               clock/reset ports.
// Ports:
//   clk, rst_n        : clock, async active-low reset (round-robin build only)
//   req_ld, req_cpu   : requests
//   gnt_ld, gnt_cpu   : grants
// ---------------------------------------------------------------------------
module rr_arb2
    import bsram_arb_pkg::*;
(
`ifdef BSRAM_ARB_RR_EN
    input  logic clk,
    input  logic rst_n,
`endif
    input  logic req_ld,
    input  logic req_cpu,
    output logic gnt_ld,
    output logic gnt_cpu
);

`ifdef BSRAM_ARB_RR_EN
    // 1: CPU was granted last, 0: loader was granted last
    logic last_cpu;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_cpu <= 1'b0;
        end else if (gnt_cpu) begin
            last_cpu <= 1'b1;
        end else if (gnt_ld) begin
            last_cpu <= 1'b0;
        end
    end

    always_comb begin
        gnt_ld  = req_ld  & (~req_cpu | last_cpu);
        gnt_cpu = req_cpu & (~req_ld  | ~last_cpu);
    end
`else
    always_comb begin
        gnt_ld  = req_ld;
        gnt_cpu = req_cpu & ~req_ld;
    end
`endif

endmodule

// File: rtl/bsram_arbiter.sv
// ---------------------------------------------------------------------------
// bsram_arbiter
// Shares one single-port BSRAM between a boot loader (writes) and a CPU
// instruction fetch port (reads). In BOOT only the loader is served and the
// CPU is held; an ld_done pulse moves to RUN, after which both ports are
// arbitrated by rr_arb2. Memory control outputs are registered and carry one
// access per cycle; read data comes straight from the BSRAM output and is
// qualified by cpu_rvalid, produced 1+RD_LAT cycles after the CPU handshake.
// Build option: BSRAM_ARB_RR_EN selects round-robin tie breaking in RUN
// (default: loader wins ties).
// Parameters: AW address width, DW data width, RD_LAT BSRAM read latency
// (1 or 2).
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : bsram_arbiter_if.slave (loader, CPU and BSRAM signals)
// ---------------------------------------------------------------------------
module bsram_arbiter
    import bsram_arb_pkg::*;
#(
    parameter int AW     = AW_DEF,
    parameter int DW     = DW_DEF,
    parameter int RD_LAT = RD_LAT_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    bsram_arbiter_if.slave  bus
);

    arb_state_t    state_q;
    arb_state_t    state_d;
    logic          cpu_req_run;
    logic          hold;
    logic          gnt_ld;
    logic          gnt_cpu;
    logic          hs_any;
    logic [AW-1:0] next_ad;
    logic [DW-1:0] next_din;

    logic          mem_ce_q;
    logic          mem_wre_q;
    logic [AW-1:0] mem_ad_q;
    logic [DW-1:0] mem_din_q;

    // bit 0 is loaded at the handshake edge; the top bit is cpu_rvalid
    logic [RD_LAT:0] rv_sr;

    // ---------------- mode FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // hold follows the registered state, so it drops in the first RUN cycle.
    // The CPU request is masked in BOOT, which makes the arbiter pass the
    // loader request straight through as its grant.
    always_comb begin
        state_d     = state_q;
        cpu_req_run = 1'b0;
        hold        = 1'b1;
        case (state_q)
            BOOT: begin
                if (bus.ld_done) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                cpu_req_run = bus.cpu_req;
                hold        = 1'b0;
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // ---------------- grant logic ----------------
    rr_arb2 u_rr_arb2 (
`ifdef BSRAM_ARB_RR_EN
        .clk     (clk),
        .rst_n   (rst_n),
`endif
        .req_ld  (bus.ld_req),
        .req_cpu (cpu_req_run),
        .gnt_ld  (gnt_ld),
        .gnt_cpu (gnt_cpu)
    );

    // grants are only raised with their request, so a grant is a handshake
    always_comb begin
        hs_any   = gnt_ld | gnt_cpu;
        next_ad  = mem_ad_q;
        next_din = mem_din_q;
        if (gnt_ld) begin
            next_ad  = bus.ld_addr;
            next_din = bus.ld_wdata;
        end else if (gnt_cpu) begin
            next_ad  = bus.cpu_addr;
        end
    end

    // ---------------- registered memory port ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_ce_q  <= 1'b0;
            mem_wre_q <= 1'b0;
            mem_ad_q  <= '0;
            mem_din_q <= '0;
        end else begin
            mem_ce_q  <= hs_any;
            mem_wre_q <= gnt_ld;
            mem_ad_q  <= next_ad;
            mem_din_q <= next_din;
        end
    end

    // ---------------- read-valid pipeline ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rv_sr <= '0;
        end else begin
            rv_sr <= {rv_sr[RD_LAT-1:0], gnt_cpu};
        end
    end

    // ---------------- outputs ----------------
    assign bus.ld_gnt     = gnt_ld;
    assign bus.cpu_gnt    = gnt_cpu;
    assign bus.cpu_hold   = hold;
    assign bus.cpu_rvalid = rv_sr[RD_LAT];
    assign bus.cpu_rdata  = bus.mem_dout;
    assign bus.mem_ce     = mem_ce_q;
    assign bus.mem_wre    = mem_wre_q;
    assign bus.mem_ad     = mem_ad_q;
    assign bus.mem_din    = mem_din_q;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_bsram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bsram_arbiter
// Two arbiter instances share one stimulus stream: dut_a with RD_LAT=1 and
// dut_b with RD_LAT=2, each with its own BSRAM model. The driver pushes the
// expected read word and arrival cycle when it sees a CPU grant; per-instance
// monitors pop and compare whenever cpu_rvalid is high.
// ---------------------------------------------------------------------------
module tb_bsram_arbiter;
    import bsram_arb_pkg::*;

    localparam int AW = 11;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    logic [DW-1:0] exp_qa[$];
    int            cyc_qa[$];
    logic [DW-1:0] exp_qb[$];
    int            cyc_qb[$];
    logic          discard = 1'b0;

    int   wre_cnt = 0;
    logic cnt_en = 1'b0;

    logic lg;
    logic cg;
    logic [3:0] exp_ld_tie;
    logic [3:0] exp_cpu_tie;

    bsram_arbiter_if #(.AW(AW), .DW(DW)) ifc_a ();
    bsram_arbiter_if #(.AW(AW), .DW(DW)) ifc_b ();

    bsram_arbiter #(.AW(AW), .DW(DW), .RD_LAT(1)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc_a.slave)
    );

    bsram_arbiter #(.AW(AW), .DW(DW), .RD_LAT(2)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc_b.slave)
    );

    assign ifc_b.ld_req   = ifc_a.ld_req;
    assign ifc_b.ld_addr  = ifc_a.ld_addr;
    assign ifc_b.ld_wdata = ifc_a.ld_wdata;
    assign ifc_b.ld_done  = ifc_a.ld_done;
    assign ifc_b.cpu_req  = ifc_a.cpu_req;
    assign ifc_b.cpu_addr = ifc_a.cpu_addr;

    // ---------------- BSRAM models ----------------
    logic [DW-1:0] mem_a [0:(1<<AW)-1];
    logic [DW-1:0] mem_b [0:(1<<AW)-1];
    logic [DW-1:0] dout_a = '0;
    logic [DW-1:0] d1_b = '0;
    logic [DW-1:0] dout_b = '0;

    always @(posedge clk) begin
        if (ifc_a.mem_ce) begin
            if (ifc_a.mem_wre) mem_a[ifc_a.mem_ad] <= ifc_a.mem_din;
            else               dout_a <= mem_a[ifc_a.mem_ad];
        end
    end

    always @(posedge clk) begin
        if (ifc_b.mem_ce) begin
            if (ifc_b.mem_wre) mem_b[ifc_b.mem_ad] <= ifc_b.mem_din;
            else               d1_b <= mem_b[ifc_b.mem_ad];
        end
        dout_b <= d1_b;
    end

    assign ifc_a.mem_dout = dout_a;
    assign ifc_b.mem_dout = dout_b;

    always @(negedge clk) begin
        if (cnt_en && ifc_a.mem_wre) wre_cnt++;
    end

    // ---------------- monitors ----------------
    always @(negedge clk) begin : mon_a
        logic [DW-1:0] e;
        int c;
        if (ifc_a.cpu_rvalid) begin
            vectors++;
            if (exp_qa.size() == 0) begin
                miscompares++;
                $display("FAIL rvalid_a_unexpected: rvalid at cycle %0d data %h, none expected", cyc, ifc_a.cpu_rdata);
            end else begin
                e = exp_qa.pop_front();
                c = cyc_qa.pop_front();
                if (ifc_a.cpu_rdata !== e || cyc != c) begin
                    miscompares++;
                    $display("FAIL rdata_a: got %h at cycle %0d, want %h at cycle %0d", ifc_a.cpu_rdata, cyc, e, c);
                end
            end
        end
    end

    always @(negedge clk) begin : mon_b
        logic [DW-1:0] e;
        int c;
        if (ifc_b.cpu_rvalid) begin
            vectors++;
            if (exp_qb.size() == 0) begin
                miscompares++;
                $display("FAIL rvalid_b_unexpected: rvalid at cycle %0d data %h, none expected", cyc, ifc_b.cpu_rdata);
            end else begin
                e = exp_qb.pop_front();
                c = cyc_qb.pop_front();
                if (ifc_b.cpu_rdata !== e || cyc != c) begin
                    miscompares++;
                    $display("FAIL rdata_b: got %h at cycle %0d, want %h at cycle %0d", ifc_b.cpu_rdata, cyc, e, c);
                end
            end
        end
    end

    // ---------------- driver / check tasks ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Called just after a falling edge: drives one cycle of requests, samples
    // the combinational grants, records expected reads, waits a full cycle.
    task automatic step(input logic lr, input logic [AW-1:0] la, input logic [DW-1:0] lw,
                        input logic cr, input logic [AW-1:0] ca, input logic [DW-1:0] cexp,
                        output logic lgo, output logic cgo);
        ifc_a.ld_req   = lr;
        ifc_a.ld_addr  = la;
        ifc_a.ld_wdata = lw;
        ifc_a.cpu_req  = cr;
        ifc_a.cpu_addr = ca;
        #1;
        lgo = ifc_a.ld_gnt;
        cgo = ifc_a.cpu_gnt;
        chk("gnt_ld_a_vs_b", ifc_b.ld_gnt, ifc_a.ld_gnt);
        if (ifc_a.cpu_gnt && !discard) begin
            exp_qa.push_back(cexp);
            cyc_qa.push_back(cyc + 2);
        end
        if (ifc_b.cpu_gnt && !discard) begin
            exp_qb.push_back(cexp);
            cyc_qb.push_back(cyc + 3);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        logic l;
        logic c;
        for (int k = 0; k < n; k++) step(1'b0, '0, '0, 1'b0, '0, '0, l, c);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- main sequence ----------------
    initial begin
        ifc_a.ld_req   = 1'b0;
        ifc_a.ld_addr  = '0;
        ifc_a.ld_wdata = '0;
        ifc_a.ld_done  = 1'b0;
        ifc_a.cpu_req  = 1'b0;
        ifc_a.cpu_addr = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);

        // reset values
        chk("rst_hold_a",   ifc_a.cpu_hold,   1);
        chk("rst_ce_a",     ifc_a.mem_ce,     0);
        chk("rst_wre_a",    ifc_a.mem_wre,    0);
        chk("rst_ad_a",     ifc_a.mem_ad,     0);
        chk("rst_din_a",    ifc_a.mem_din,    0);
        chk("rst_rvalid_a", ifc_a.cpu_rvalid, 0);
        chk("rst_state_a",  ifc_a.state,      BOOT);
        chk("rst_hold_b",   ifc_b.cpu_hold,   1);
        chk("rst_rvalid_b", ifc_b.cpu_rvalid, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // CPU kept out while booting
        for (int i = 0; i < 100; i++) begin
            step(1'b0, '0, '0, 1'b1, 11'd3, '0, lg, cg);
            chk("boot_cpu_gnt", cg, 0);
            chk("boot_hold", ifc_a.cpu_hold, 1);
        end

        // boot image: 12 words at addresses 0..11
        wre_cnt = 0;
        cnt_en  = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, AW'(i), DW'(16'h1000 + i), 1'b0, '0, '0, lg, cg);
            chk("boot_ld_gnt", lg, 1);
        end
        chk("wr_ce",    ifc_a.mem_ce,  1);
        chk("wr_wre",   ifc_a.mem_wre, 1);
        chk("wr_ad",    ifc_a.mem_ad,  11);
        chk("wr_din",   ifc_a.mem_din, 16'h100B);
        chk("pre_done_hold", ifc_a.cpu_hold, 1);

        ifc_a.ld_done = 1'b1;
        step(1'b0, '0, '0, 1'b0, '0, '0, lg, cg);
        ifc_a.ld_done = 1'b0;
        chk("boot_ld_gnt_idle", lg, 0);
        #1;
        chk("wre_count",    wre_cnt, 12);
        chk("run_hold",     ifc_a.cpu_hold, 0);
        chk("run_state",    ifc_a.state, RUN);
        chk("idle_ce",      ifc_a.mem_ce, 0);
        chk("idle_wre",     ifc_a.mem_wre, 0);
        chk("idle_ad_hold", ifc_a.mem_ad, 11);
        chk("idle_din_hold", ifc_a.mem_din, 16'h100B);
        cnt_en = 1'b0;
        @(negedge clk);

        // first fetch: address 3
        step(1'b0, '0, '0, 1'b1, 11'd3, 16'h1003, lg, cg);
        chk("lone_cpu_gnt", cg, 1);
        chk("lone_cpu_ld_gnt", lg, 0);
        chk("rd_ce",  ifc_a.mem_ce,  1);
        chk("rd_wre", ifc_a.mem_wre, 0);
        chk("rd_ad",  ifc_a.mem_ad,  3);
        idle(4);

        // ld_done has no effect in RUN
        ifc_a.ld_done = 1'b1;
        idle(1);
        ifc_a.ld_done = 1'b0;
        chk("done_in_run_state", ifc_a.state, RUN);
        chk("done_in_run_hold",  ifc_a.cpu_hold, 0);

        // write then read the same address on consecutive cycles
        step(1'b1, 11'd5, 16'h00A1, 1'b0, '0, '0, lg, cg);
        chk("lone_ld_gnt", lg, 1);
        step(1'b0, '0, '0, 1'b1, 11'd5, 16'h00A1, lg, cg);
        chk("raw_cpu_gnt", cg, 1);
        idle(5);

        // three back-to-back reads
        step(1'b0, '0, '0, 1'b1, 11'd1, 16'h1001, lg, cg);
        step(1'b0, '0, '0, 1'b1, 11'd2, 16'h1002, lg, cg);
        step(1'b0, '0, '0, 1'b1, 11'd3, 16'h1003, lg, cg);
        idle(5);

        // reset one cycle after a read handshake: the read is dropped
        discard = 1'b1;
        step(1'b0, '0, '0, 1'b1, 11'd4, '0, lg, cg);
        discard = 1'b0;
        chk("flush_rd_gnt", cg, 1);
        rst_n = 1'b0;
        ifc_a.cpu_req = 1'b0;
        repeat (2) @(negedge clk);
        chk("flush_hold_a",   ifc_a.cpu_hold,   1);
        chk("flush_rvalid_a", ifc_a.cpu_rvalid, 0);
        chk("flush_rvalid_b", ifc_b.cpu_rvalid, 0);
        chk("flush_state_a",  ifc_a.state,      BOOT);
        rst_n = 1'b1;
        idle(4);
        chk("flush_hold_after", ifc_a.cpu_hold, 1);

        // ties after a fresh boot
        ifc_a.ld_done = 1'b1;
        idle(1);
        ifc_a.ld_done = 1'b0;
`ifdef BSRAM_ARB_RR_EN
        exp_cpu_tie = 4'b0101;
        exp_ld_tie  = 4'b1010;
`else
        exp_cpu_tie = 4'b0000;
        exp_ld_tie  = 4'b1111;
`endif
        for (int i = 0; i < 4; i++) begin
            step(1'b1, AW'(30 + i), DW'(16'h2000 + i), 1'b1, 11'd3, 16'h1003, lg, cg);
            chk("tie_cpu_gnt", cg, exp_cpu_tie[i]);
            chk("tie_ld_gnt",  lg, exp_ld_tie[i]);
        end
        idle(8);

        chk("drain_a", exp_qa.size(), 0);
        chk("drain_b", exp_qb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
